// File: rtl/reg_bank_4x8_pkg.sv
// Shared sizing defaults and controller state encoding for the 4x8 register bank.
package reg_bank_4x8_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_4x8_if.sv
// Bus bundle for the register bank: write port, two read ports, clear control and status.
interface reg_bank_4x8_if;
  import reg_bank_4x8_pkg::*;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr0;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata0;
  logic             clr;
  logic             busy;
  logic             wack;

  modport master (
    output we, waddr, wdata, raddr1, raddr0, clr,
    input  rdata1, rdata0, busy, wack
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr0, clr,
    output rdata1, rdata0, busy, wack
  );

endinterface

// File: rtl/reg_bank_4x8_reg8_en.sv
// Single storage register with synchronous reset, synchronous zero and load enable.
module reg8_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             zero_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Zero wins over load so a clear step can never be overwritten by a stray write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else if (zero_i) begin
      q_q <= {WIDTH{1'b0}};
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_bank_4x8.sv
// Four-entry register bank: two registered read ports with write/clear bypass,
// one write port, and a one-register-per-cycle clear sequence.
module reg_bank_4x8 import reg_bank_4x8_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  reg_bank_4x8_if.slave  bus
);

  logic [WIDTH-1:0] reg_s [DEPTH];
  logic [DEPTH-1:0] ld_s;
  logic [DEPTH-1:0] zero_s;

  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic             busy_q;
  logic             wack_q;
  logic [WIDTH-1:0] rdata1_q;
  logic [WIDTH-1:0] rdata0_q;
  logic [WIDTH-1:0] rdata1_d;
  logic [WIDTH-1:0] rdata0_d;

  logic wr_acc_s;
  logic clr_act_s;

  // A read sees the value the register will hold after this edge: fresh write data, or zero if being cleared.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]    raddr,
    input logic [WIDTH-1:0] stored,
    input logic             wr_acc,
    input logic [AW-1:0]    waddr,
    input logic [WIDTH-1:0] wdata,
    input logic             clr_act,
    input logic [AW-1:0]    idx
  );
    logic [WIDTH-1:0] val;
    if (wr_acc && (raddr == waddr)) begin
      val = wdata;
    end else if (clr_act && (raddr == idx)) begin
      val = {WIDTH{1'b0}};
    end else begin
      val = stored;
    end
    return val;
  endfunction

  assign wr_acc_s  = bus.we && (state_q == ST_IDLE) && !bus.clr;
  assign clr_act_s = (state_q == ST_CLEAR);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ld_s[i]   = wr_acc_s && (bus.waddr == AW'(i));
      zero_s[i] = clr_act_s && (idx_q == AW'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_regs
    reg8_en #(.WIDTH(WIDTH)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .en_i   (ld_s[g]),
      .zero_i (zero_s[g]),
      .d_i    (bus.wdata),
      .q_o    (reg_s[g])
    );
  end

  always_comb begin
    rdata1_d = read_port(bus.raddr1, reg_s[bus.raddr1], wr_acc_s, bus.waddr,
                         bus.wdata, clr_act_s, idx_q);
    rdata0_d = read_port(bus.raddr0, reg_s[bus.raddr0], wr_acc_s, bus.waddr,
                         bus.wdata, clr_act_s, idx_q);
  end

  // Controller: state, clear index, status flags and read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= {AW{1'b0}};
      busy_q   <= 1'b0;
      wack_q   <= 1'b0;
      rdata1_q <= {WIDTH{1'b0}};
      rdata0_q <= {WIDTH{1'b0}};
    end else begin
      wack_q   <= wr_acc_s;
      rdata1_q <= rdata1_d;
      rdata0_q <= rdata0_d;
      case (state_q)
        ST_IDLE: begin
          idx_q <= {AW{1'b0}};
          if (bus.clr) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= {AW{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata1 = rdata1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.busy   = busy_q;
  assign bus.wack   = wack_q;

endmodule

// File: tb/tb_reg_bank_4x8.sv
// Directed plus randomized bench for reg_bank_4x8 against an array-based reference model.
module tb_reg_bank_4x8;
  import reg_bank_4x8_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_4x8_if bus();

  reg_bank_4x8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: register contents plus number of clear edges still to come.
  logic [7:0] m_reg [4];
  int         m_clear_left = 0;
  logic [7:0] m_rd1 = 8'h00;
  logic [7:0] m_rd0 = 8'h00;
  logic       m_wack = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  k;
    bit  acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
      m_clear_left = 0;
      m_rd1 = 8'h00; m_rd0 = 8'h00; m_wack = 1'b0;
    end else if (m_clear_left > 0) begin
      k = 4 - m_clear_left;
      m_rd1 = (int'(bus.raddr1) == k) ? 8'h00 : m_reg[bus.raddr1];
      m_rd0 = (int'(bus.raddr0) == k) ? 8'h00 : m_reg[bus.raddr0];
      m_reg[k] = 8'h00;
      m_clear_left--;
      m_wack = 1'b0;
    end else begin
      acc = bus.we && !bus.clr;
      m_rd1 = (acc && bus.raddr1 == bus.waddr) ? bus.wdata : m_reg[bus.raddr1];
      m_rd0 = (acc && bus.raddr0 == bus.waddr) ? bus.wdata : m_reg[bus.raddr0];
      if (acc) m_reg[bus.waddr] = bus.wdata;
      m_wack = acc;
      if (bus.clr) m_clear_left = 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rdata1", bus.rdata1, m_rd1);
    chk("rdata0", bus.rdata0, m_rd0);
    chk("busy", {7'd0, bus.busy}, {7'd0, (m_clear_left > 0)});
    chk("wack", {7'd0, bus.wack}, {7'd0, m_wack});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
    bus.we = 1'b0;
  endtask

  initial begin
    int bc;
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = 2'd0; bus.wdata = 8'h00;
    bus.raddr1 = 2'd3; bus.raddr0 = 2'd0; bus.clr = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;

    // 1: reset then read
    step(); step();
    rst = 1'b0;
    step();
    chk("t1_rd1", bus.rdata1, 8'h00);
    chk("t1_rd0", bus.rdata0, 8'h00);

    // 2: write then read back
    wr(2'd2, 8'hA5);
    chk("t2_wack_a", {7'd0, bus.wack}, 8'h01);
    wr(2'd1, 8'h3C);
    chk("t2_wack_b", {7'd0, bus.wack}, 8'h01);
    bus.raddr1 = 2'd2; bus.raddr0 = 2'd1;
    step();
    chk("t2_rd1", bus.rdata1, 8'hA5);
    chk("t2_rd0", bus.rdata0, 8'h3C);
    chk("t2_wack_off", {7'd0, bus.wack}, 8'h00);

    // 3: same-edge write bypass on port 1
    bus.raddr1 = 2'd3; bus.raddr0 = 2'd0;
    wr(2'd3, 8'h7E);
    chk("t3_bypass", bus.rdata1, 8'h7E);
    chk("t3_old", bus.rdata0, 8'h00);

    // 4: fill, clear, watch addr 3 and busy length
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    bus.raddr1 = 2'd3;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bc = bus.busy ? 1 : 0;
    bus.we = 1'b1; bus.waddr = 2'd0; bus.wdata = 8'hFF;
    step();
    chk("t4_no_wack", {7'd0, bus.wack}, 8'h00);
    chk("t4_rd3_mid", bus.rdata1, 8'h44);
    bus.we = 1'b0;
    if (bus.busy) bc++;
    for (int i = 0; i < 10 && bus.busy; i++) begin
      step();
      if (bus.busy) bc++;
    end
    chk("t4_busy_len", 8'(bc), 8'd4);
    chk("t4_rd3_final", bus.rdata1, 8'h00);
    for (int a = 0; a < 4; a++) begin
      bus.raddr1 = 2'(a); bus.raddr0 = 2'(a);
      step();
      chk("t4_zero", bus.rdata1, 8'h00);
    end

    // 5: clr and we together, clear wins
    wr(2'd1, 8'h12);
    bus.clr = 1'b1; bus.we = 1'b1; bus.waddr = 2'd1; bus.wdata = 8'h99;
    step();
    chk("t5_wack", {7'd0, bus.wack}, 8'h00);
    chk("t5_busy", {7'd0, bus.busy}, 8'h01);
    bus.clr = 1'b0; bus.we = 1'b0;
    repeat (4) step();
    bus.raddr1 = 2'd1;
    step();
    chk("t5_reg1", bus.rdata1, 8'h00);

    // 6: reset on the second busy cycle
    wr(2'd2, 8'h66); wr(2'd3, 8'h77);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    step();
    chk("t6_busy_pre", {7'd0, bus.busy}, 8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy_post", {7'd0, bus.busy}, 8'h00);
    for (int a = 0; a < 4; a++) begin
      bus.raddr1 = 2'(a); bus.raddr0 = 2'(3 - a);
      step();
      chk("t6_zero", bus.rdata1, 8'h00);
    end
    wr(2'd3, 8'h5A);
    chk("t6_wack", {7'd0, bus.wack}, 8'h01);
    bus.raddr1 = 2'd3;
    step();
    chk("t6_rd", bus.rdata1, 8'h5A);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      bus.clr    = ($urandom_range(0, 15) == 0);
      bus.we     = $urandom_range(0, 1) == 1;
      bus.waddr  = 2'($urandom_range(0, 3));
      bus.wdata  = 8'($urandom_range(0, 255));
      bus.raddr1 = 2'($urandom_range(0, 3));
      bus.raddr0 = 2'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_4x8.md
Name: reg_bank_4x8

Overview:
- Four-entry, 8-bit register bank with two registered read ports and one write port.
- Sits directly upstream of the 8-bit 2:1 operand mux: rdata1 drives the mux a1 input and rdata0 drives a0.
- Includes a multi-cycle clear-all sequence with a busy flag and a write-acknowledge pulse.

Parameters:
- WIDTH, 8, data width of each register and read/write port.
- DEPTH, 4, number of registers (power of two).
- AW, 2, address width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- we  input  1  write request
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- raddr1  input  AW  read address, port 1
- raddr0  input  AW  read address, port 0
- rdata1  output  WIDTH  registered read data, port 1 (to mux a1)
- rdata0  output  WIDTH  registered read data, port 0 (to mux a0)
- clr  input  1  request to clear all registers
- busy  output  1  clear sequence in progress; writes are refused while high
- wack  output  1  one-cycle pulse acknowledging an accepted write

Behaviour:
- Reset (rst=1 at a clock edge):
  - all registers, rdata1, rdata0, busy, wack and the clear index go to 0;
  - state goes to IDLE.
  - Reset applies in any state, including mid-clear: the sequence is aborted and all registers read 0.
- States:
  - IDLE: normal reads and writes.
  - CLEAR: one register is zeroed per cycle.
- Write acceptance:
  - A write is accepted when we=1, state=IDLE and clr=0.
  - At that edge, reg[waddr] <= wdata and wack <= 1 for exactly one cycle.
  - Otherwise wack <= 0.
- Read timing: 1-cycle latency. At each edge, rdataX <= reg[raddrX], using the contents before that edge's update.
- Write-to-read bypass:
  - If a write is accepted at the same edge and raddrX == waddr, rdataX <= wdata.
  - Both ports bypass independently.
- Clear entry: clr=1 in IDLE at edge E0 gives state <= CLEAR, idx <= 0, busy <= 1.
- Clear priority: clr has priority over we in the same cycle. The write is dropped and wack stays 0.
- Clear sequence:
  - At edges E1..E(DEPTH) in CLEAR: reg[idx] <= 0 and idx <= idx+1.
  - At the edge that clears reg[DEPTH-1]: state <= IDLE and busy <= 0.
  - busy is therefore high for exactly DEPTH cycles.
- While busy=1:
  - we is ignored (no wack) and clr is ignored (no restart).
  - Reads continue. A read of the register being cleared at that edge returns 0 (clear bypass).
  - Other registers return their current, possibly already-cleared, value.
- idx wraps naturally at DEPTH. It is don't-care in IDLE but is held at 0.
- Arithmetic: there is no arithmetic on data. idx is an AW-bit unsigned counter.
- There are no combinational paths from inputs to outputs. All outputs are flops.

Decomposition:
- Shared package holds:
  - WIDTH/DEPTH/AW defaults;
  - the state encoding: IDLE=1'b0, CLEAR=1'b1.
- One natural sub-module: reg8_en. It is a WIDTH-bit register with synchronous active-high reset, load enable and synchronous zero.
- reg8_en is instantiated DEPTH times. The top holds the FSM, the clear counter, the read muxes and the bypass logic.

Test Plan:
1. Reset then read: assert rst for 2 cycles, raddr1=3, raddr0=0 → next cycle rdata1=0x00, rdata0=0x00, busy=0, wack=0.
2. Write/read: write 0xA5 to addr 2, then 0x3C to addr 1 → wack pulses each cycle. Then raddr1=2, raddr0=1 → one cycle later rdata1=0xA5, rdata0=0x3C.
3. Bypass: we=1, waddr=3, wdata=0x7E with raddr1=3 in the same cycle → rdata1=0x7E at the next edge. rdata0 (raddr0=0) shows the old reg[0].
4. Clear: fill regs with 0x11/0x22/0x33/0x44, pulse clr → busy high for exactly 4 cycles.
   - A we=1 to addr 0 with 0xFF during busy produces no wack.
   - Afterwards all regs read 0x00.
   - Reading addr 3 mid-clear returns 0x44 until its clear edge, then 0x00.
5. Simultaneous clr+we: clr=1, we=1, waddr=1, wdata=0x99 → wack=0, busy=1 next cycle, reg[1] ends at 0x00.
6. Reset mid-clear: assert rst on the 2nd busy cycle → next cycle busy=0, state IDLE, all regs read 0. A subsequent write of 0x5A to addr 3 is accepted with wack=1.
